uart_rx_fifo_feeder: RTL

Serial byte receiver that sits directly upstream of the 16-entry byte FIFO and feeds its write port. It samples an asynchronous 8N1 serial line, assembles bytes LSB-first, and issues a single-cycle write strobe with the byte whenever the FIFO is not full. Bytes arriving while the FIFO is full are dropped and counted. Frames with a bad stop bit are reported and discarded.

---
 rtl/uart_rx_fifo_feeder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_feeder.sv
// 8N1 serial receiver that writes each good byte into a downstream byte FIFO.
// Bytes arriving while the FIFO is full are dropped and counted; bad stop bits are flagged.
module uart_rx_fifo_feeder #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_in,
  input  logic       i_full,
  output logic       o_wr,
  output logic [7:0] o_din,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_busy,
  output logic [7:0] o_drop_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  logic          r_sync1, r_rx_s;
  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_idx, w_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          w_wr_next, w_overrun_next, w_ferr_next;
  logic          r_wr, r_overrun, r_frame_err;
  logic [7:0]    r_din, r_drop_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= i_rx_in;
      r_rx_s  <= r_sync1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
    w_wr_next      = 1'b0;
    w_overrun_next = 1'b0;
    w_ferr_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The detection cycle is already the first cycle of the start bit.
        if (!r_rx_s) begin
          w_state_next = S_START;
          w_cnt_next   = CW'(1);
        end
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_next = '0;
          w_idx_next = 3'd0;
          w_state_next = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {r_rx_s, r_shift[7:1]};
          w_idx_next   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_next = '0;
          if (r_rx_s) begin
            w_wr_next      = !i_full;
            w_overrun_next = i_full;
            w_state_next   = S_IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_wr        <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_din       <= 8'h00;
      r_drop_cnt  <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_shift     <= w_shift_next;
      r_wr        <= w_wr_next;
      r_overrun   <= w_overrun_next;
      r_frame_err <= w_ferr_next;
      if (w_wr_next) r_din <= r_shift;
      if (w_overrun_next && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_wr        = r_wr;
  assign o_din       = r_din;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != S_IDLE);
  assign o_drop_cnt  = r_drop_cnt;

endmodule
